// File: rtl/axis_frame_reader_if.sv
// -----------------------------------------------------------------------------
// axis_frame_reader_if
// AXI-stream bundle between a stream FIFO output and the frame reader.
//   tdata  : stream data word
//   tvalid : word is valid
//   tready : sink accepts the word this cycle
//   tlast  : word is the last of its frame
//   tuser  : sideband carried with the word
// Modports: master drives the stream (FIFO side), slave consumes it (reader).
// -----------------------------------------------------------------------------
interface axis_frame_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_reader.sv
// -----------------------------------------------------------------------------
// axis_frame_reader
// Drains frames from an AXI-stream FIFO output and hands them, one word per
// host strobe, to a register interface. Tracks frame length, reports frame
// completion and lets the host discard the remainder of the current frame.
//
// Ports:
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   s_axis        : AXI-stream slave (tdata/tvalid/tready/tlast/tuser)
//   reg_rd_en     : host pop strobe, one word per asserted cycle
//   reg_rd_ack    : one-cycle pulse, one cycle after reg_rd_en
//   reg_rd_data   : popped word (zero on underflow)
//   reg_rd_last   : popped word carried tlast
//   reg_rd_user   : popped word tuser
//   reg_rd_empty  : strobe found no word, qualified by reg_rd_ack
//   reg_avail     : a word is held and readable
//   flush         : discard the rest of the current frame
//   frame_done    : one-cycle pulse when a frame's last word is consumed
//   frame_flushed : frame_done was caused by a flush
//   frame_len     : word count of the last completed frame (saturating)
// -----------------------------------------------------------------------------
module axis_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_frame_reader_if.slave    s_axis,
    input  logic                  reg_rd_en,
    output logic                  reg_rd_ack,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_last,
    output logic [USER_WIDTH-1:0] reg_rd_user,
    output logic                  reg_rd_empty,
    output logic                  reg_avail,
    input  logic                  flush,
    output logic                  frame_done,
    output logic                  frame_flushed,
    output logic [LEN_WIDTH-1:0]  frame_len
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] c);
        return (&c) ? c : c + LEN_ONE;
    endfunction

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  cnt, cnt_nxt, cnt_p1, cnt_p2;
    logic [LEN_WIDTH-1:0]  len_nxt;
    logic                  done_nxt, flushed_nxt;
    logic                  ack_nxt, empty_nxt, last_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [USER_WIDTH-1:0] user_nxt;
    logic                  load;
    logic                  tready_int;
    logic                  beat;

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;
    logic [USER_WIDTH-1:0] hold_user;

    // The held word is valid exactly while in HOLD.
    assign reg_avail = (state == ST_HOLD);

    // Ready depends only on state and the pop strobe so it never loops back
    // through tvalid; in HOLD the pop frees the register for a same-cycle refill.
    always_comb begin
        tready_int = 1'b1;
        case (state)
            ST_IDLE:  tready_int = 1'b1;
            ST_HOLD:  tready_int = reg_rd_en;
            ST_FLUSH: tready_int = 1'b1;
            default:  tready_int = 1'b1;
        endcase
    end

    assign s_axis.tready = tready_int;
    assign beat          = s_axis.tvalid & tready_int;

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        cnt_nxt     = cnt;
        len_nxt     = frame_len;
        done_nxt    = 1'b0;
        flushed_nxt = 1'b0;
        // Default reply to a strobe is an underflow; overridden when a word is popped.
        ack_nxt     = reg_rd_en;
        empty_nxt   = reg_rd_en;
        data_nxt    = '0;
        last_nxt    = 1'b0;
        user_nxt    = '0;
        cnt_p1      = sat_inc(cnt);
        cnt_p2      = sat_inc(cnt_p1);

        case (state)
            ST_IDLE: begin
                if (flush) begin
                    // A beat arriving with the flush is the first word of the
                    // frame being discarded.
                    if (beat && s_axis.tlast) begin
                        done_nxt    = 1'b1;
                        flushed_nxt = 1'b1;
                        len_nxt     = cnt_p1;
                        cnt_nxt     = '0;
                    end else begin
                        state_nxt = ST_FLUSH;
                        if (beat) cnt_nxt = cnt_p1;
                    end
                end else if (beat) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    if (hold_last) begin
                        // Held word closes the frame; a same-cycle beat starts
                        // the next frame and is kept.
                        done_nxt    = 1'b1;
                        flushed_nxt = 1'b1;
                        len_nxt     = cnt_p1;
                        cnt_nxt     = '0;
                        if (beat) load = 1'b1;
                        else      state_nxt = ST_IDLE;
                    end else if (beat && s_axis.tlast) begin
                        // Held word and the incoming last beat are both discarded.
                        done_nxt    = 1'b1;
                        flushed_nxt = 1'b1;
                        len_nxt     = cnt_p2;
                        cnt_nxt     = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = beat ? cnt_p2 : cnt_p1;
                    end
                end else if (reg_rd_en) begin
                    empty_nxt = 1'b0;
                    data_nxt  = hold_data;
                    last_nxt  = hold_last;
                    user_nxt  = hold_user;
                    if (hold_last) begin
                        done_nxt = 1'b1;
                        len_nxt  = cnt_p1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_p1;
                    end
                    if (beat) load = 1'b1;
                    else      state_nxt = ST_IDLE;
                end
            end

            ST_FLUSH: begin
                if (beat) begin
                    if (s_axis.tlast) begin
                        done_nxt    = 1'b1;
                        flushed_nxt = 1'b1;
                        len_nxt     = cnt_p1;
                        cnt_nxt     = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt_p1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            frame_len     <= '0;
            frame_done    <= 1'b0;
            frame_flushed <= 1'b0;
            reg_rd_ack    <= 1'b0;
            reg_rd_empty  <= 1'b0;
            reg_rd_data   <= '0;
            reg_rd_last   <= 1'b0;
            reg_rd_user   <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            frame_len     <= len_nxt;
            frame_done    <= done_nxt;
            frame_flushed <= flushed_nxt;
            reg_rd_ack    <= ack_nxt;
            reg_rd_empty  <= empty_nxt;
            reg_rd_data   <= data_nxt;
            reg_rd_last   <= last_nxt;
            reg_rd_user   <= user_nxt;
        end
    end

    // Holding register contents are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= s_axis.tdata;
            hold_last <= s_axis.tlast;
            hold_user <= s_axis.tuser;
        end
    end

endmodule

// File: tb/tb_axis_frame_reader.sv
module tb_axis_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tdata;
    logic       tvalid, tlast;
    logic [0:0] tuser;
    logic       rd_en, flush;

    axis_frame_reader_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) ax_a ();
    axis_frame_reader_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) ax_b ();

    assign ax_a.tdata  = tdata;
    assign ax_a.tvalid = tvalid;
    assign ax_a.tlast  = tlast;
    assign ax_a.tuser  = tuser;
    assign ax_b.tdata  = tdata;
    assign ax_b.tvalid = tvalid;
    assign ax_b.tlast  = tlast;
    assign ax_b.tuser  = tuser;

    logic        ack_a, last_a, empty_a, avail_a, done_a, flushed_a;
    logic [7:0]  data_a;
    logic [0:0]  user_a;
    logic [15:0] len_a;
    logic        ack_b, last_b, empty_b, avail_b, done_b, flushed_b;
    logic [7:0]  data_b;
    logic [0:0]  user_b;
    logic [1:0]  len_b;

    axis_frame_reader #(.DATA_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_axis(ax_a), .reg_rd_en(rd_en),
        .reg_rd_ack(ack_a), .reg_rd_data(data_a), .reg_rd_last(last_a),
        .reg_rd_user(user_a), .reg_rd_empty(empty_a), .reg_avail(avail_a),
        .flush(flush), .frame_done(done_a), .frame_flushed(flushed_a),
        .frame_len(len_a)
    );

    axis_frame_reader #(.DATA_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .s_axis(ax_b), .reg_rd_en(rd_en),
        .reg_rd_ack(ack_b), .reg_rd_data(data_b), .reg_rd_last(last_b),
        .reg_rd_user(user_b), .reg_rd_empty(empty_b), .reg_avail(avail_b),
        .flush(flush), .frame_done(done_b), .frame_flushed(flushed_b),
        .frame_len(len_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       empty;
    } ack_t;

    typedef struct {
        int   cyc;
        int   n;
        logic fl;
    } done_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } word_t;

    ack_t  ackq[$];
    done_t doneq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: words waiting for the host, whether the rest of a frame
    // is being dropped, and the number of words consumed from the current frame.
    word_t m_words[$];
    bit    m_dropping = 0;
    int    m_count = 0;
    int    m_last_len = 0;

    function automatic int clip(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic consume_word(input logic is_last, input logic by_flush);
        done_t d;
        m_count++;
        if (is_last) begin
            d.cyc = cyc + 1;
            d.n = m_count;
            d.fl = by_flush;
            doneq.push_back(d);
            m_last_len = m_count;
            m_count = 0;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic u, input logic rd, input logic fl, input logic r);
        ack_t  a;
        word_t w;
        bit    exp_ready, accepted, flush_eff;
        @(negedge clk);
        checks++;
        if (avail_a !== (m_words.size() > 0)) begin
            errors++;
            $display("FAIL avail cyc=%0d got %b want %b", cyc, avail_a, m_words.size() > 0);
        end
        checks++;
        if (int'(len_a) != clip(m_last_len, 65535) || int'(len_b) != clip(m_last_len, 3)) begin
            errors++;
            $display("FAIL frame_len cyc=%0d got %0d/%0d want %0d/%0d", cyc, len_a, len_b,
                     clip(m_last_len, 65535), clip(m_last_len, 3));
        end
        tvalid = v; tdata = d; tlast = l; tuser = u; rd_en = rd; flush = fl; rst = r;
        if (r) begin
            m_words.delete();
            m_dropping = 0;
            m_count = 0;
            m_last_len = 0;
            return;
        end
        exp_ready = (m_words.size() == 0) ? 1'b1 : rd;
        accepted  = v && exp_ready;
        flush_eff = fl && !m_dropping;
        if (rd) begin
            a.cyc = cyc + 1;
            if (m_words.size() > 0 && !flush_eff) begin
                w = m_words.pop_front();
                a.data = w.data; a.last = w.last; a.user = w.user; a.empty = 1'b0;
                consume_word(w.last, 1'b0);
            end else begin
                a.data = 8'h00; a.last = 1'b0; a.user = 1'b0; a.empty = 1'b1;
            end
            ackq.push_back(a);
        end
        if (flush_eff) begin
            if (m_words.size() > 0) begin
                w = m_words.pop_front();
                consume_word(w.last, 1'b1);
                if (!w.last) m_dropping = 1;
            end else begin
                m_dropping = 1;
            end
        end
        if (accepted) begin
            if (m_dropping) begin
                consume_word(l, 1'b1);
                if (l) m_dropping = 0;
            end else begin
                w.data = d; w.last = l; w.user = u;
                m_words.push_back(w);
            end
        end
        #1;
        checks++;
        if (ax_a.tready !== exp_ready || ax_b.tready !== exp_ready) begin
            errors++;
            $display("FAIL tready cyc=%0d got %b want %b", cyc, ax_a.tready, exp_ready);
        end
    endtask

    // Monitor: compare every presented ack / frame_done with the scoreboard.
    always @(negedge clk) begin
        ack_t  ea;
        done_t ed;
        if (ack_a === 1'b1) begin
            checks++;
            if (ackq.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected cyc=%0d data=%h empty=%b", cyc, data_a, empty_a);
            end else begin
                ea = ackq.pop_front();
                if (ea.cyc != cyc || data_a !== ea.data || last_a !== ea.last ||
                    user_a !== ea.user || empty_a !== ea.empty) begin
                    errors++;
                    $display("FAIL ack cyc=%0d got d=%h l=%b u=%b e=%b want cyc=%0d d=%h l=%b u=%b e=%b",
                             cyc, data_a, last_a, user_a, empty_a, ea.cyc, ea.data, ea.last,
                             ea.user, ea.empty);
                end
            end
        end else begin
            while (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
                ea = ackq.pop_front();
                checks++;
                errors++;
                $display("FAIL ack_missing cyc=%0d got none want d=%h e=%b", cyc, ea.data, ea.empty);
            end
        end

        if (done_a === 1'b1) begin
            checks++;
            if (doneq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d len=%0d fl=%b", cyc, len_a, flushed_a);
            end else begin
                ed = doneq.pop_front();
                if (ed.cyc != cyc || done_b !== 1'b1 || flushed_a !== ed.fl ||
                    flushed_b !== ed.fl || int'(len_a) != clip(ed.n, 65535) ||
                    int'(len_b) != clip(ed.n, 3)) begin
                    errors++;
                    $display("FAIL done cyc=%0d got len=%0d/%0d fl=%b/%b want cyc=%0d len=%0d/%0d fl=%b",
                             cyc, len_a, len_b, flushed_a, flushed_b, ed.cyc,
                             clip(ed.n, 65535), clip(ed.n, 3), ed.fl);
                end
            end
        end else begin
            while (doneq.size() > 0 && doneq[0].cyc <= cyc) begin
                ed = doneq.pop_front();
                checks++;
                errors++;
                $display("FAIL done_missing cyc=%0d got none want len=%0d", cyc, ed.n);
            end
        end

        if (done_a === 1'b0 && flushed_a !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL flushed_without_done cyc=%0d got %b want 0", cyc, flushed_a);
        end
        if (done_b !== done_a && done_a !== 1'bx) begin
            checks++;
            errors++;
            $display("FAIL done_sat_align cyc=%0d got %b want %b", cyc, done_b, done_a);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Beat i of an n-word frame with the host popping on every cycle.
    task automatic frame_streamed(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            step(1'b1, base + 8'(i), (i == n - 1), 1'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0;
        rd_en = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);

        // Pop with nothing held right after reset.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Three-word frame, host pops as soon as a word is available.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Eight-beat frame with continuous pop.
        frame_streamed(8, 8'h40);
        idle(2);

        // Six-word frame: pop two, flush, remainder dropped; next frame normal.
        step(1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h65, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame_streamed(3, 8'h70);
        idle(2);

        // Five-word frame: saturates the 2-bit length counter.
        frame_streamed(5, 8'h80);
        idle(2);

        // Reset while dropping a frame, then a fresh frame.
        step(1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame_streamed(3, 8'hA0);
        idle(2);

        // Flush in IDLE between frames drops the whole next frame.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 599) == 0);
        end

        idle(4);
        @(negedge clk);
        checks++;
        if (ackq.size() != 0 || doneq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d acks %0d dones pending want 0", ackq.size(), doneq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
